// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_arb_pkg;

  localparam logic MASTER_DATA  = 1'b0;
  localparam logic MASTER_INSTR = 1'b1;

  typedef enum logic {
    IDLE_ARB = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Bits needed to hold an occupancy count from 0 up to max_out inclusive.
  function automatic int count_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of 1-bit master ids, one entry per granted request still
// waiting for its response.
module owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] slots_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = slots_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        slots_q[wr_ptr_q] <= push_id;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master (data cache, instruction cache) to one-slave arbiter with
// zero-latency req/gnt forwarding, round-robin choice and in-order routing
// of responses back to the issuing master.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE_ARB | no pending unaccepted request; winner picked from live reqs
// LOCKED   | slave has seen a request but not granted it; winner frozen
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_error_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_error_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic        mem_req_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_error_i,
  output logic        protocol_error_o
);

  lock_state_e state_q, state_d;
  logic        lock_id_q, lock_id_d;
  logic        rr_q;
  logic        win_id;
  logic        win_req;
  logic        grant;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_head;

  // Winner selection: frozen while locked, otherwise live requests with rr tie-break.
  always_comb begin
    win_id = MASTER_DATA;
    if (state_q == LOCKED) begin
      win_id = lock_id_q;
    end else if (m0_req_i && m1_req_i) begin
      win_id = rr_q;
    end else if (m1_req_i) begin
      win_id = MASTER_INSTR;
    end
    win_req = (win_id == MASTER_INSTR) ? m1_req_i : m0_req_i;
  end

  // Full is judged on the registered count, so a same-cycle response never unblocks issue.
  assign mem_req_o = win_req & ~fifo_full;
  assign grant     = mem_req_o & mem_gnt_i;
  assign m0_gnt_o  = grant & (win_id == MASTER_DATA);
  assign m1_gnt_o  = grant & (win_id == MASTER_INSTR);

  // Slave-side request fields follow the winner, and read as zero when it is not requesting.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    if (win_req) begin
      if (win_id == MASTER_INSTR) begin
        mem_addr_o  = m1_addr_i;
        mem_wdata_o = m1_wdata_i;
        mem_we_o    = m1_we_i;
        mem_be_o    = m1_be_i;
      end else begin
        mem_addr_o  = m0_addr_i;
        mem_wdata_o = m0_wdata_i;
        mem_we_o    = m0_we_i;
        mem_be_o    = m0_be_i;
      end
    end
  end

  // Lock next-state: hold the winner from the first unaccepted request until the slave grants.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE_ARB: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d   = LOCKED;
          lock_id_d = win_id;
        end
      end
      LOCKED: begin
        if (mem_gnt_i) begin
          state_d = IDLE_ARB;
        end
      end
      default: state_d = IDLE_ARB;
    endcase
  end

  // Lock state, locked id, rr pointer and the sticky orphan-response flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE_ARB;
      lock_id_q        <= MASTER_DATA;
      rr_q             <= MASTER_DATA;
      protocol_error_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      if (grant) begin
        rr_q <= ~win_id;
      end
      if (mem_rvalid_i && fifo_empty) begin
        protocol_error_o <= 1'b1;
      end
    end
  end

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (grant),
    .push_id (win_id),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Responses with nobody waiting are dropped rather than routed.
  assign pop         = mem_rvalid_i & ~fifo_empty;
  assign m0_rvalid_o = pop & (fifo_head == MASTER_DATA);
  assign m1_rvalid_o = pop & (fifo_head == MASTER_INSTR);
  assign m0_error_o  = m0_rvalid_o & mem_error_i;
  assign m1_error_o  = m1_rvalid_o & mem_error_i;
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-master to one-slave arbiter sitting directly downstream of the cache memory-side ports.
- Master 0 is the data-side cache and master 1 is the instruction-side cache. The single slave port drives the memory/bus interconnect.
- It forwards req/gnt with zero added latency and picks a winner round-robin. It records the owner of each granted request in an in-order FIFO so every rvalid/rdata is routed back to the master that issued it.

Parameters:
MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests on the slave port (1..8)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
m0_addr_i / m1_addr_i  input  32  master request address
m0_wdata_i / m1_wdata_i  input  32  master write data
m0_we_i / m1_we_i  input  1  master write enable
m0_be_i / m1_be_i  input  4  master byte enables
m0_req_i / m1_req_i  input  1  master request, held until gnt
m0_gnt_o / m1_gnt_o  output  1  request accepted this cycle
m0_rvalid_o / m1_rvalid_o  output  1  response valid for this master
m0_rdata_o / m1_rdata_o  output  32  response data (mem_rdata_i broadcast to both)
m0_error_o / m1_error_o  output  1  mem_error_i qualified by that master's rvalid
mem_addr_o, mem_wdata_o  output  32  selected master's address/data
mem_we_o  output  1  selected write enable
mem_be_o  output  4  selected byte enables
mem_req_o  output  1  request to slave
mem_rdata_i  input  32  slave read data
mem_gnt_i  input  1  slave accept
mem_rvalid_i  input  1  slave response valid, in order
mem_error_i  input  1  slave error, valid with rvalid
protocol_error_o  output  1  sticky: rvalid received with no outstanding request

Behaviour:
- Reset (async):
  - owner FIFO empty; count=0.
  - rr pointer favours m0; lock cleared; protocol_error_o=0.
  - With no master requesting, all gnt/rvalid/mem_req outputs are 0 and mem_* data outputs are 0.
  - Reset during an outstanding transaction discards it; later rvalids are then flagged via protocol_error_o.
- Selection (combinational, two states):
  - IDLE_ARB (lock=0): winner is the requesting master. If both request, winner is the one favoured by the rr pointer.
  - LOCKED (lock=1): winner is the locked master regardless of other requests.
  - Transitions:
    - IDLE_ARB -> LOCKED when mem_req_o & ~mem_gnt_i; the winner is registered.
    - LOCKED -> IDLE_ARB on mem_gnt_i.
  - This guarantees the address/data presented to the slave stay stable until granted.
- Issue rules:
  - mem_req_o = winner's req & (count < MAX_OUTSTANDING).
  - mem_addr/wdata/we/be mux the winner's fields.
  - mX_gnt_o = mem_gnt_i & mem_req_o & (winner==X); gnt is zero-cycle combinational.
  - On a grant: push the winner id into the owner FIFO and set the rr pointer to favour the other master.
  - When count==MAX_OUTSTANDING, issue is blocked even if a pop happens the same cycle.
- Response routing:
  - On mem_rvalid_i with FIFO non-empty: pop the head and assert rvalid for the head's master in the same cycle. That master's error = mem_error_i.
  - Simultaneous push and pop are allowed; count is unchanged and FIFO order is preserved.
  - mem_rvalid_i with FIFO empty: the response is dropped, no master rvalid is asserted, and protocol_error_o is set and held until reset.
- A master dropping req before gnt is a master protocol violation. The arbiter still holds lock until gnt; no check is required.
- count width is clog2(MAX_OUTSTANDING+1). FIFO pointers wrap modulo MAX_OUTSTANDING.

Decomposition:
- Package mem_arb_pkg holds:
  - master-id constants MASTER_DATA=0 and MASTER_INSTR=1
  - lock state encoding IDLE_ARB/LOCKED
  - localparam function for the count width
- Sub-module owner_fifo: 1-bit wide, depth MAX_OUTSTANDING, with push/pop/full/empty/head. It uses the same clk and async active-high reset.

Test Plan:
- Single master: m0 reads addr 0x100, slave gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> m0_gnt_o in cycle 0; m0_rvalid_o=1 with data 0xDEADBEEF in cycle 2; m1_rvalid_o stays 0.
- Contention: both request every cycle, slave always grants -> grants alternate m0,m1,m0,m1 starting with m0 after reset; rvalids are routed in the same order.
- Lock: m1 requests addr 0x200 with gnt held low 3 cycles while m0 raises req in cycle 1 -> mem_addr_o stays 0x200 for all 4 cycles; m1 is granted in cycle 3 and m0 in cycle 4.
- Outstanding limit (MAX_OUTSTANDING=2): 3 back-to-back grants attempted with no rvalid -> mem_req_o drops after 2 grants; it re-rises the cycle after the first rvalid.
- Simultaneous push/pop: grant m1 in the same cycle as the rvalid for an earlier m0 request -> m0_rvalid_o=1 that cycle; the next rvalid goes to m1; count never exceeds 2.
- Fault/reset: rvalid with mem_error_i=1 for an m0 request -> m0_error_o=1. Then assert reset with 1 outstanding and send rvalid after reset -> no master rvalid and protocol_error_o=1 until the next reset.
